// File: rtl/audio_nios_sd_dat_rx.sv
// Avalon-MM SD 4-bit DAT receiver with sd_clk generator, byte FIFO and flow-control stall.
// Define SD_DAT_RX_CRC_EN to enable per-line CRC16 checking of the received block.
module audio_nios_sd_dat_rx #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic        read_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sd_clk,
    input  logic [3:0]  sd_dat
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StWaitStart, StData, StCrc, StEnd, StDone} state_e;

    state_e        state_q;
    logic [7:0]    div_q, div_cnt_q;
    logic [9:0]    blklen_q;
    logic [10:0]   byte_cnt_q;
    logic [TW-1:0] tcnt_q;
    logic [3:0]    crc_cnt_q, hi_q;
    logic          nibble_q, sd_clk_q;
    logic          done_q, timeout_q, crc_err_q;
    logic [31:0]   readdata_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic wr_en, rd_en, ctrl_wr, start, abort;
    logic running, phase_end, stall, sample, push, pop, busy, crc_bad;
    logic unused_wdata;

    assign wr_en     = chipselect && !write_n;
    assign rd_en     = chipselect && !read_n;
    assign ctrl_wr   = wr_en && (address == 3'd0);
    assign abort     = ctrl_wr && writedata[1];
    assign start     = ctrl_wr && writedata[0] && !writedata[1];
    assign busy      = (state_q != StIdle);
    assign running   = (state_q == StWaitStart) || (state_q == StData) ||
                       (state_q == StCrc) || (state_q == StEnd);
    assign phase_end = (div_cnt_q >= div_q);
    // Hold sd_clk low before the next rise while the FIFO cannot take another full byte.
    assign stall     = (state_q == StData) && (count_q >= CW'(FIFO_DEPTH - 1));
    assign sample    = running && !sd_clk_q && phase_end && !stall;
    assign push      = (state_q == StData) && sample && nibble_q;
    assign pop       = rd_en && (address == 3'd2) && (count_q != '0);
    assign sd_clk    = sd_clk_q;
    assign readdata  = readdata_q;
    assign unused_wdata = ^writedata[31:10];

`ifdef SD_DAT_RX_CRC_EN
    logic [3:0][15:0] crc_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= '0;
        end else if (state_q == StIdle && start) begin
            crc_q <= '0;
        end else if (sample && (state_q == StData || state_q == StCrc)) begin
            for (int i = 0; i < 4; i++) crc_q[i] <= crc16_step(crc_q[i], sd_dat[i]);
        end
    end

    assign crc_bad = |crc_q;
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {hi_q, sd_dat};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q    <= 8'h3F;
            blklen_q <= 10'd512;
        end else if (wr_en) begin
            if (address == 3'd3) div_q    <= writedata[7:0];
            if (address == 3'd4) blklen_q <= writedata[9:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            case (address)
                3'd1:    readdata_q <= {17'b0, 7'(count_q), 4'b0,
                                        crc_err_q, timeout_q, done_q, busy};
                3'd2:    readdata_q <= pop ? {24'b0, mem[rd_ptr_q]} : 32'h0;
                3'd3:    readdata_q <= {24'b0, div_q};
                3'd4:    readdata_q <= {22'b0, blklen_q};
                default: readdata_q <= 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sd_clk_q   <= 1'b0;
            div_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tcnt_q     <= '0;
            crc_cnt_q  <= '0;
            hi_q       <= '0;
            nibble_q   <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            crc_err_q  <= 1'b0;
        end else if (abort) begin
            state_q   <= StIdle;
            sd_clk_q  <= 1'b0;
            div_cnt_q <= '0;
            nibble_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (running) begin
                if (!phase_end) begin
                    div_cnt_q <= div_cnt_q + 8'd1;
                end else if (sd_clk_q || !stall) begin
                    sd_clk_q  <= !sd_clk_q;
                    div_cnt_q <= '0;
                end
            end
            case (state_q)
                StIdle: begin
                    sd_clk_q  <= 1'b0;
                    div_cnt_q <= '0;
                    if (start) begin
                        state_q    <= StWaitStart;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        crc_err_q  <= 1'b0;
                        byte_cnt_q <= (blklen_q == '0) ? 11'd1024 : {1'b0, blklen_q};
                        tcnt_q     <= '0;
                        crc_cnt_q  <= '0;
                        nibble_q   <= 1'b0;
                    end
                end
                StWaitStart: if (sample) begin
                    if (sd_dat == 4'h0) begin
                        state_q <= StData;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                StData: if (sample) begin
                    if (!nibble_q) begin
                        hi_q     <= sd_dat;
                        nibble_q <= 1'b1;
                    end else begin
                        nibble_q   <= 1'b0;
                        byte_cnt_q <= byte_cnt_q - 11'd1;
                        if (byte_cnt_q == 11'd1) state_q <= StCrc;
                    end
                end
                StCrc: if (sample) begin
                    crc_cnt_q <= crc_cnt_q + 4'd1;
                    if (crc_cnt_q == 4'd15) state_q <= StEnd;
                end
                StEnd: if (sample) begin
                    if (sd_dat != 4'hF || crc_bad) crc_err_q <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    sd_clk_q  <= 1'b0;
                    div_cnt_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_nios_sd_dat_rx.sv
// Directed bench for audio_nios_sd_dat_rx: a cycle-stepped SD card model feeds DAT nibbles
// on each sd_clk rise while the host side exercises the Avalon register interface.
module tb_audio_nios_sd_dat_rx;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic        read_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        sd_clk;
    logic [3:0]  sd_dat = 4'hF;

    int total = 0;
    int bad = 0;
    logic [3:0] stream[$];
    logic [7:0] payload[$];
    int   idx = 0;
    int   rises = 0;
    logic prev_clk = 1'b0;
    logic [31:0] d, s;
    logic got;
    logic [31:0] exp_crc_status;

    audio_nios_sd_dat_rx #(
        .FIFO_DEPTH(16),
        .TIMEOUT   (100)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .read_n    (read_n),
        .writedata (writedata),
        .readdata  (readdata),
        .sd_clk    (sd_clk),
        .sd_dat    (sd_dat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clk cycle; the card presents its next nibble after every observed sd_clk rise.
    task automatic tick();
        @(negedge clk);
        if (sd_clk === 1'b1 && prev_clk === 1'b0) begin
            rises++;
            idx++;
            sd_dat = (idx < stream.size()) ? stream[idx] : 4'hF;
        end
        prev_clk = sd_clk;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
        address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
        address = a; chipselect = 1'b1; read_n = 1'b0;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        v = readdata;
    endtask

    // Start nibble, payload high-then-low nibbles, per-line CRC16 MSB first, end nibble.
    task automatic build(input logic flip_dat2);
        logic [15:0] crc [4];
        logic [3:0]  nib;
        logic [7:0]  b;
        logic        fb;
        stream.delete();
        stream.push_back(4'h0);
        for (int l = 0; l < 4; l++) crc[l] = 16'h0;
        for (int i = 0; i < payload.size(); i++) begin
            b = payload[i];
            for (int h = 1; h >= 0; h--) begin
                nib = (h == 1) ? b[7:4] : b[3:0];
                stream.push_back(nib);
                for (int l = 0; l < 4; l++) begin
                    fb = crc[l][15] ^ nib[l];
                    crc[l] = {crc[l][14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                end
            end
        end
        for (int k = 15; k >= 0; k--) begin
            for (int l = 0; l < 4; l++) nib[l] = crc[l][k];
            if (flip_dat2 && k == 15) nib[2] = ~nib[2];
            stream.push_back(nib);
        end
        stream.push_back(4'hF);
        idx = 0;
        sd_dat = stream[0];
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            bus_rd(3'd1, st);
            if (st[1]) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'h1);
    endtask

    task automatic read_bytes(input string tag, input int first, input int last);
        logic [31:0] v;
        for (int i = first; i <= last; i++) begin
            bus_rd(3'd2, v);
            check(tag, v, {24'b0, payload[i]});
        end
    endtask

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #2;
        check("rst_sd_clk", {31'b0, sd_clk}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        bus_rd(3'd1, d); check("rst_status", d, 32'h0);
        bus_rd(3'd3, d); check("rst_div", d, 32'h3F);
        bus_rd(3'd4, d); check("rst_blklen", d, 32'h200);
        bus_rd(3'd0, d); check("ctrl_reads0", d, 32'h0);

        // Basic 4-byte block, correct CRC
        bus_wr(3'd3, 32'h1);
        bus_wr(3'd4, 32'h4);
        payload = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        build(1'b0);
        bus_wr(3'd0, 32'h1);
        bus_rd(3'd1, d); check("busy_after_start", d, 32'h1);
        wait_done("blk4_done");
        read_bytes("blk4_data", 0, 3);
        bus_rd(3'd1, d); check("blk4_status", d, 32'h2);
        bus_rd(3'd2, d); check("empty_read", d, 32'h0);

        // Same block, one CRC bit flipped on DAT2
        build(1'b1);
        bus_wr(3'd0, 32'h1);
        wait_done("crcflip_done");
        read_bytes("crcflip_data", 0, 3);
`ifdef SD_DAT_RX_CRC_EN
        exp_crc_status = 32'h0A;
`else
        exp_crc_status = 32'h02;
`endif
        bus_rd(3'd1, d); check("crcflip_status", d, exp_crc_status);

        // 64-byte block with the FIFO left unread: stall at 15, release per read
        bus_wr(3'd4, 32'd64);
        payload.delete();
        for (int i = 0; i < 64; i++) payload.push_back(8'((i * 37 + 5) & 8'hFF));
        build(1'b0);
        bus_wr(3'd0, 32'h1);
        repeat (400) tick();
        bus_rd(3'd1, d); check("stall_status", d, 32'h0F01);
        check("stall_sd_clk", {31'b0, sd_clk}, 32'h0);
        rises = 0;
        repeat (40) tick();
        check("stall_no_rise", rises, 32'h0);
        bus_rd(3'd1, d); check("stall_status2", d, 32'h0F01);
        for (int i = 0; i < 49; i++) begin
            bus_rd(3'd2, d);
            check("flow_data", d, {24'b0, payload[i]});
            repeat (12) tick();
        end
        wait_done("flow_done");
        read_bytes("flow_tail", 49, 63);
        bus_rd(3'd1, d); check("flow_status", d, 32'h2);

        // Start bit never arrives: timeout after 100 samples
        stream.delete();
        idx = 0;
        sd_dat = 4'hF;
        rises = 0;
        bus_wr(3'd0, 32'h1);
        repeat (1000) tick();
        check("timeout_rises", rises, 32'd100);
        check("timeout_sd_clk", {31'b0, sd_clk}, 32'h0);
        bus_rd(3'd1, d); check("timeout_status", d, 32'h06);

        // ABORT after two bytes, then a clean block
        bus_wr(3'd4, 32'h4);
        payload = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(1'b0);
        bus_wr(3'd0, 32'h1);
        got = 1'b0;
        for (int n = 0; n < 500 && !got; n++) begin
            bus_rd(3'd1, s);
            if (s[14:8] == 7'd2) got = 1'b1;
        end
        check("abort_two_bytes", {31'b0, got}, 32'h1);
        bus_wr(3'd0, 32'h2);
        bus_rd(3'd1, d); check("abort_status", d, 32'h0);
        bus_rd(3'd2, d); check("abort_data", d, 32'h0);
        check("abort_sd_clk", {31'b0, sd_clk}, 32'h0);
        payload = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
        build(1'b0);
        bus_wr(3'd0, 32'h1);
        wait_done("after_abort_done");
        read_bytes("after_abort_data", 0, 3);
        bus_rd(3'd1, d); check("after_abort_status", d, 32'h2);

        // Reset pulsed mid-DATA while sd_clk is high
        build(1'b0);
        bus_wr(3'd0, 32'h1);
        rises = 0;
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            tick();
            if (rises >= 6 && sd_clk === 1'b1) got = 1'b1;
        end
        check("mid_data_reached", {31'b0, got}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_sd_clk", {31'b0, sd_clk}, 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        bus_rd(3'd3, d); check("midrst_div", d, 32'h3F);
        bus_rd(3'd4, d); check("midrst_blklen", d, 32'h200);
        rises = 0;
        repeat (20) tick();
        check("midrst_no_clock", rises, 32'h0);
        bus_rd(3'd1, d); check("midrst_status", d, 32'h0);
        bus_rd(3'd2, d); check("midrst_data", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
